// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode validity helper for the
// ALU arbiter slice.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return (op <= OP_OR);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted requester so that
// under contention the other one wins next.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant0 = valid0;
        grant1 = valid1;
        if (valid0 && valid1) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (grant0 || grant1)) begin
            last_grant_d = grant1;
        end
    end

    // Reset value 1 makes requester 0 the first winner under contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin grant,
// latency counting and tagged responses. Optional rsp_err port: ALU_ARB_ERR_EN.
module alu_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int OP_W    = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
`ifdef ALU_ARB_ERR_EN
    output logic              rsp_err,
`endif
    output logic [DATA_W-1:0] rsp_data
);

    import alu_pkg::*;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_ERR_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    logic              idle;
    logic              grant0;
    logic              grant1;
    logic              take;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign idle = (state_q == IDLE);

    // Valids are masked outside IDLE so the arbiter only grants when we can accept.
    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid0  (req0_valid && idle),
        .valid1  (req1_valid && idle),
        .advance (take),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign take       = grant0 || grant1;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_ARB_ERR_EN
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    rsp_id_d = grant1;
                    cnt_d    = '0;
`ifdef ALU_ARB_ERR_EN
                    rsp_err_d = 1'b0;
                    if (!is_valid_op(sel_op)) begin
                        // Illegal opcode never touches the ALU.
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        cnt_d    = (sel_op == OP_MUL) ? MUL_CNT : 4'd0;
                        state_d  = EXEC;
                    end
`else
                    alu_op_d = is_valid_op(sel_op) ? sel_op : OP_ADD;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    cnt_d    = (sel_op == OP_MUL) ? MUL_CNT : 4'd0;
                    state_d  = EXEC;
`endif
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = alu_result;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_ARB_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_ARB_ERR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
`ifdef ALU_ARB_ERR_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a combinational ALU model;
// covers both builds of ALU_ARB_ERR_EN.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
`ifdef ALU_ARB_ERR_EN
    logic        rsp_err;
`endif

    int assert_count = 0;
    int fail_count   = 0;
    int lat;

    alu_arbiter #(.MUL_LAT(4), .OP_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
`ifdef ALU_ARB_ERR_EN
        .rsp_err    (rsp_err),
`endif
        .rsp_data   (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            4'd3:    alu_result = alu_a & alu_b;
            4'd4:    alu_result = alu_a | alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic v, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Called in the grant cycle; returns cycles from grant to rsp_valid, checking
    // that ready drops after the grant and alu_op holds through EXEC.
    task automatic waitRsp(input logic [1:0] drop, input logic [3:0] exp_op, output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                checkOutput("ready_after_grant", 64'({req0_ready, req1_ready}), 64'd0);
                if (drop[0]) req0_valid = 1'b0;
                if (drop[1]) req1_valid = 1'b0;
            end
            #1;
            if (rsp_valid === 1'b1) break;
            checkOutput("alu_op_hold", 64'(alu_op), 64'(exp_op));
        end
    endtask

    task automatic finishRsp();
        @(posedge clk);
        #2;
        checkOutput("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    logic [3:0]  t_op0 [3] = '{4'd1, 4'd3, 4'd4};
    logic [31:0] t_a0  [3] = '{32'd20, 32'h0000F0F0, 32'd1};
    logic [31:0] t_b0  [3] = '{32'd5,  32'h0000FF00, 32'd2};
    logic [31:0] t_r0  [3] = '{32'd15, 32'h0000F000, 32'd3};
    logic [3:0]  t_op1 [3] = '{4'd3, 4'd4, 4'd1};
    logic [31:0] t_a1  [3] = '{32'hC, 32'h10, 32'd3};
    logic [31:0] t_b1  [3] = '{32'hA, 32'h01, 32'd5};
    logic [31:0] t_r1  [3] = '{32'h8, 32'h11, 32'hFFFFFFFE};

    initial begin
        int idx0, idx1, exp_id;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(0, 1'b0, 4'd0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("reset_alu", 64'({alu_op, alu_a, alu_b} != 68'd0), 64'd0);
        checkOutput("reset_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'd0);
        checkOutput("reset_ready", 64'({req0_ready, req1_ready}), 64'd0);
`ifdef ALU_ARB_ERR_EN
        checkOutput("reset_err", 64'(rsp_err), 64'd0);
`endif

        $display("[TB] req0 ADD 5+7");
        applyStimulus(0, 1'b1, 4'd0, 32'd5, 32'd7);
        #1;
        checkOutput("add_ready", 64'({req0_ready, req1_ready}), 64'b10);
        waitRsp(2'b01, 4'd0, lat);
        checkOutput("add_latency", 64'(lat), 64'd2);
        checkOutput("add_id", 64'(rsp_id), 64'd0);
        checkOutput("add_data", 64'(rsp_data), 64'd12);
`ifdef ALU_ARB_ERR_EN
        checkOutput("add_err", 64'(rsp_err), 64'd0);
`endif
        finishRsp();

        $display("[TB] req1 MUL 6*9");
        applyStimulus(1, 1'b1, 4'd2, 32'd6, 32'd9);
        #1;
        checkOutput("mul_ready", 64'({req0_ready, req1_ready}), 64'b01);
        waitRsp(2'b10, 4'd2, lat);
        checkOutput("mul_latency", 64'(lat), 64'd5);
        checkOutput("mul_id", 64'(rsp_id), 64'd1);
        checkOutput("mul_data", 64'(rsp_data), 64'd54);
        finishRsp();

        $display("[TB] contention, six ops");
        idx0 = 0;
        idx1 = 0;
        applyStimulus(0, 1'b1, t_op0[0], t_a0[0], t_b0[0]);
        applyStimulus(1, 1'b1, t_op1[0], t_a1[0], t_b1[0]);
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_id = k % 2;
            checkOutput("rr_ready", 64'({req0_ready, req1_ready}), (exp_id == 0) ? 64'b10 : 64'b01);
            waitRsp(2'b00, (exp_id == 0) ? t_op0[idx0] : t_op1[idx1], lat);
            checkOutput("rr_latency", 64'(lat), 64'd2);
            checkOutput("rr_id", 64'(rsp_id), 64'(exp_id));
            checkOutput("rr_data", 64'(rsp_data), (exp_id == 0) ? 64'(t_r0[idx0]) : 64'(t_r1[idx1]));
            if (exp_id == 0) begin
                idx0++;
                if (idx0 < 3) applyStimulus(0, 1'b1, t_op0[idx0], t_a0[idx0], t_b0[idx0]);
                else          req0_valid = 1'b0;
            end else begin
                idx1++;
                if (idx1 < 3) applyStimulus(1, 1'b1, t_op1[idx1], t_a1[idx1], t_b1[idx1]);
                else          req1_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rr_idle_valid", 64'(rsp_valid), 64'd0);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 4'd0, 32'd100, 32'd23);
        applyStimulus(1, 1'b1, 4'd1, 32'd9, 32'd1);
        #1;
        checkOutput("bp_ready", 64'({req0_ready, req1_ready}), 64'b10);
        waitRsp(2'b01, 4'd0, lat);
        checkOutput("bp_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            checkOutput("bp_hold", 64'({rsp_valid, rsp_data, req0_ready, req1_ready}),
                        64'({1'b1, 32'd123, 1'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("bp_release", 64'({rsp_valid, req0_ready, req1_ready}), 64'b001);
        req1_valid = 1'b0;

        $display("[TB] reset during MUL");
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 4'd2, 32'd7, 32'd8);
        #1;
        checkOutput("abort_grant", 64'({req0_ready, req1_ready}), 64'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        #1;
        checkOutput("abort_exec_op", 64'(alu_op), 64'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("abort_outputs", 64'({alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data} != 101'd0), 64'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #2;
            checkOutput("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(0, 1'b1, 4'd0, 32'd0, 32'd0);
        applyStimulus(1, 1'b1, 4'd0, 32'd0, 32'd0);
        #1;
        checkOutput("abort_next_grant", 64'({req0_ready, req1_ready}), 64'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("[TB] unknown opcode 9");
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 4'd9, 32'd10, 32'd4);
        #1;
        checkOutput("bad_ready", 64'({req0_ready, req1_ready}), 64'b10);
        waitRsp(2'b01, 4'd0, lat);
`ifdef ALU_ARB_ERR_EN
        checkOutput("bad_latency", 64'(lat), 64'd1);
        checkOutput("bad_err", 64'(rsp_err), 64'd1);
        checkOutput("bad_data", 64'(rsp_data), 64'd0);
        checkOutput("bad_alu_a", 64'(alu_a), 64'd0);
`else
        checkOutput("bad_latency", 64'(lat), 64'd2);
        checkOutput("bad_data", 64'(rsp_data), 64'd14);
        checkOutput("bad_alu_op", 64'(alu_op), 64'd0);
        checkOutput("bad_alu_a", 64'(alu_a), 64'd10);
`endif
        checkOutput("bad_id", 64'(rsp_id), 64'd0);
        finishRsp();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
